muldiv_scheduler: RTL and testbench



---
 rtl/muldiv_scheduler_pkg.sv | 40 ++++
 rtl/muldiv_iter_core.sv | 59 +++++
 rtl/muldiv_scheduler.sv | 182 ++++++++++++++++++
 tb/tb_muldiv_scheduler.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/muldiv_scheduler_pkg.sv
// rtl/muldiv_scheduler_pkg.sv - shared op/state encodings and op decode helpers for the muldiv scheduler
package muldiv_scheduler_pkg;

  localparam int XLEN_DEF = 32;

  // RV32M funct3 encodings
  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  // FSM state encodings
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  function automatic logic op_is_div(input logic [2:0] op);
    return op[2];
  endfunction

  // rs1 treated as signed
  function automatic logic op_sa(input logic [2:0] op);
    return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  // rs2 treated as signed
  function automatic logic op_sb(input logic [2:0] op);
    return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  // Result comes from the high half: product high word or remainder
  function automatic logic op_hi_word(input logic [2:0] op);
    return op[2] ? op[1] : (op != OP_MUL);
  endfunction

endpackage

// File: rtl/muldiv_iter_core.sv
// rtl/muldiv_iter_core.sv - one shift-add multiply / restoring divide step plus sign fix-up of the stepped value
module muldiv_iter_core
  import muldiv_scheduler_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic            is_div,
  input  logic [XLEN-1:0] hi,
  input  logic [XLEN-1:0] lo,
  input  logic [XLEN-1:0] opb,
  input  logic            neg_lo,
  input  logic            neg_hi,
  output logic [XLEN-1:0] hi_nxt,
  output logic [XLEN-1:0] lo_nxt,
  output logic [XLEN-1:0] res_hi,
  output logic [XLEN-1:0] res_lo
);

  logic [XLEN:0]     sum;
  logic [XLEN:0]     shifted;
  logic [XLEN:0]     diff;
  logic [2*XLEN-1:0] prod;
  logic [2*XLEN-1:0] prod_fix;

  // Multiply: lo holds the multiplier and is shifted out LSB first while the product shifts in.
  // Divide: lo holds the dividend, shifted out MSB first while quotient bits shift in.
  always_comb begin
    sum     = {1'b0, hi} + (lo[0] ? {1'b0, opb} : {(XLEN+1){1'b0}});
    shifted = {hi, lo[XLEN-1]};
    diff    = shifted - {1'b0, opb};
    if (is_div) begin
      if (!diff[XLEN]) begin
        hi_nxt = diff[XLEN-1:0];
        lo_nxt = {lo[XLEN-2:0], 1'b1};
      end else begin
        hi_nxt = shifted[XLEN-1:0];
        lo_nxt = {lo[XLEN-2:0], 1'b0};
      end
    end else begin
      hi_nxt = sum[XLEN:1];
      lo_nxt = {sum[0], lo[XLEN-1:1]};
    end
  end

  // Signs reapplied to the stepped value; only meaningful on the last iteration.
  // The product is negated as one double-width number; quotient and remainder independently.
  always_comb begin
    prod     = {hi_nxt, lo_nxt};
    prod_fix = neg_hi ? (~prod + 1'b1) : prod;
    if (is_div) begin
      res_lo = neg_lo ? (~lo_nxt + 1'b1) : lo_nxt;
      res_hi = neg_hi ? (~hi_nxt + 1'b1) : hi_nxt;
    end else begin
      res_lo = prod_fix[XLEN-1:0];
      res_hi = prod_fix[2*XLEN-1:XLEN];
    end
  end

endmodule

// File: rtl/muldiv_scheduler.sv
// rtl/muldiv_scheduler.sv - RV32M iterative mul/div sequencer with stall and flush; optional MULDIV_RESULT_CACHE_EN result cache
module muldiv_scheduler
  import muldiv_scheduler_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_EX,
  input  logic [2:0]      op_EX,
  input  logic [XLEN-1:0] src1_EX,
  input  logic [XLEN-1:0] src2_EX,
  input  logic [4:0]      wr_EX,
  input  logic            flush,
  output logic            stop_EX,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      wr_out
);

  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  logic [1:0]      state;
  logic [CW-1:0]   cnt;
  logic [2:0]      op_q;
  logic [4:0]      wr_q;
  logic [XLEN-1:0] hi_q;
  logic [XLEN-1:0] lo_q;
  logic [XLEN-1:0] b_q;
  logic            neg_lo_q;
  logic            neg_hi_q;

  logic            is_div_in, sa, sb, a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            div_zero, div_ovf, special;
  logic [XLEN-1:0] spec_res;
  logic            quick;
  logic [XLEN-1:0] quick_res;

  logic [XLEN-1:0] hi_nxt, lo_nxt, res_hi, res_lo;
  logic            is_div_q;

`ifdef MULDIV_RESULT_CACHE_EN
  logic            c_vld;
  logic            c_div, c_sa, c_sb;
  logic [XLEN-1:0] c_a, c_b, c_hi, c_lo;
  logic [XLEN-1:0] src1_q, src2_q;
  logic            hit;
`endif

  // Decode the incoming request: signedness, magnitudes and the one-cycle special cases
  always_comb begin
    is_div_in = op_is_div(op_EX);
    sa        = op_sa(op_EX);
    sb        = op_sb(op_EX);
    a_neg     = sa & src1_EX[XLEN-1];
    b_neg     = sb & src2_EX[XLEN-1];
    a_mag     = a_neg ? (~src1_EX + 1'b1) : src1_EX;
    b_mag     = b_neg ? (~src2_EX + 1'b1) : src2_EX;
    div_zero  = is_div_in && (src2_EX == '0);
    div_ovf   = is_div_in && sa && (src1_EX == MIN_NEG) && (src2_EX == '1);
    special   = div_zero | div_ovf;
    if (op_hi_word(op_EX))
      spec_res = div_zero ? src1_EX : '0;
    else
      spec_res = div_zero ? '1 : MIN_NEG;
`ifdef MULDIV_RESULT_CACHE_EN
    hit       = c_vld && (c_a == src1_EX) && (c_b == src2_EX) &&
                (c_div == is_div_in) && (c_sa == sa) && (c_sb == sb);
    quick     = special | hit;
    if (special)
      quick_res = spec_res;
    else
      quick_res = op_hi_word(op_EX) ? c_hi : c_lo;
`else
    quick     = special;
    quick_res = spec_res;
`endif
  end

  assign is_div_q = op_is_div(op_q);

  muldiv_iter_core #(.XLEN(XLEN)) u_core (
    .is_div (is_div_q),
    .hi     (hi_q),
    .lo     (lo_q),
    .opb    (b_q),
    .neg_lo (neg_lo_q),
    .neg_hi (neg_hi_q),
    .hi_nxt (hi_nxt),
    .lo_nxt (lo_nxt),
    .res_hi (res_hi),
    .res_lo (res_lo)
  );

  // Stall the pipeline for the whole operation except the cycle the result is handed back
  assign stop_EX = start_EX && (state != ST_DONE);
  assign busy    = (state != ST_IDLE);
  assign done    = (state == ST_DONE);

  // FSM, operand latching, iteration and result capture; flush overrides everything but reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      op_q     <= '0;
      wr_q     <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      b_q      <= '0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      result   <= '0;
      wr_out   <= '0;
`ifdef MULDIV_RESULT_CACHE_EN
      c_vld    <= 1'b0;
      c_div    <= 1'b0;
      c_sa     <= 1'b0;
      c_sb     <= 1'b0;
      c_a      <= '0;
      c_b      <= '0;
      c_hi     <= '0;
      c_lo     <= '0;
      src1_q   <= '0;
      src2_q   <= '0;
`endif
    end else if (flush) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_EX) begin
            op_q <= op_EX;
            wr_q <= wr_EX;
            if (quick) begin
              result <= quick_res;
              wr_out <= wr_EX;
              state  <= ST_DONE;
            end else begin
              hi_q     <= '0;
              lo_q     <= a_mag;
              b_q      <= b_mag;
              neg_lo_q <= a_neg ^ b_neg;
              neg_hi_q <= is_div_in ? a_neg : (a_neg ^ b_neg);
              cnt      <= '0;
              state    <= ST_CALC;
`ifdef MULDIV_RESULT_CACHE_EN
              src1_q   <= src1_EX;
              src2_q   <= src2_EX;
`endif
            end
          end
        end
        ST_CALC: begin
          hi_q <= hi_nxt;
          lo_q <= lo_nxt;
          cnt  <= cnt + 1'b1;
          if (cnt == CW'(XLEN-1)) begin
            result <= op_hi_word(op_q) ? res_hi : res_lo;
            wr_out <= wr_q;
            state  <= ST_DONE;
`ifdef MULDIV_RESULT_CACHE_EN
            c_vld  <= 1'b1;
            c_div  <= is_div_q;
            c_sa   <= op_sa(op_q);
            c_sb   <= op_sb(op_q);
            c_a    <= src1_q;
            c_b    <= src2_q;
            c_hi   <= res_hi;
            c_lo   <= res_lo;
`endif
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_scheduler.sv
// tb/tb_muldiv_scheduler.sv - scoreboard bench for muldiv_scheduler; MULDIV_RESULT_CACHE_EN selects cached latencies
module tb_muldiv_scheduler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_EX = 1'b0;
  logic [2:0]  op_EX = 3'd0;
  logic [31:0] src1_EX = '0;
  logic [31:0] src2_EX = '0;
  logic [4:0]  wr_EX = '0;
  logic        flush = 1'b0;
  logic        stop_EX, busy, done;
  logic [31:0] result;
  logic [4:0]  wr_out;

  int total = 0;
  int bad = 0;

`ifdef MULDIV_RESULT_CACHE_EN
  localparam int CLAT = 1;
`else
  localparam int CLAT = 33;
`endif

  typedef struct packed {
    logic [31:0] res;
    logic [4:0]  wr;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];

  muldiv_scheduler #(.XLEN(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_EX (start_EX),
    .op_EX    (op_EX),
    .src1_EX  (src1_EX),
    .src2_EX  (src2_EX),
    .wr_EX    (wr_EX),
    .flush    (flush),
    .stop_EX  (stop_EX),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .wr_out   (wr_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got result %h wr %0d want no done", result, wr_out);
      end else begin
        exp_t  e;
        string n;
        e = exp_q.pop_front();
        n = name_q.pop_front();
        check({n, "_result"}, result, e.res);
        check({n, "_wr"}, 32'(wr_out), 32'(e.wr));
      end
    end
  end

  task automatic issue(input string name, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] wr, input logic [31:0] exp,
                       input int lat);
    exp_t e;
    int   c;
    bit   stall_ok;
    e.res = exp;
    e.wr  = wr;
    exp_q.push_back(e);
    name_q.push_back(name);
    @(posedge clk); #1;
    op_EX = op; src1_EX = a; src2_EX = b; wr_EX = wr; start_EX = 1'b1;
    c = 0;
    stall_ok = 1'b1;
    forever begin
      @(negedge clk);
      if (done) break;
      if (!stop_EX) stall_ok = 1'b0;
      c++;
      if (c > 100) break;
    end
    check({name, "_latency"}, 32'(c), 32'(lat));
    check({name, "_stall"}, 32'({stall_ok, stop_EX}), 32'd2);
    @(posedge clk); #1;
    start_EX = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_wr", 32'(wr_out), 32'd0);
    check("rst_stop", 32'(stop_EX), 32'd0);
    #1 rst_n = 1'b1;

    issue("mul_7x6",   3'b000, 32'd7,          32'd6,          5'd3,  32'd42,         33);
    issue("mul_neg",   3'b000, 32'hFFFFFFFD,   32'd5,          5'd9,  32'hFFFFFFF1,   33);
    issue("div_neg",   3'b100, 32'hFFFFFFF9,   32'd2,          5'd4,  32'hFFFFFFFD,   33);
    issue("rem_neg",   3'b110, 32'hFFFFFFF9,   32'd2,          5'd5,  32'hFFFFFFFF,   CLAT);
    issue("divu_7_2",  3'b101, 32'd7,          32'd2,          5'd6,  32'd3,          33);
    issue("divu_by0",  3'b101, 32'd5,          32'd0,          5'd10, 32'hFFFFFFFF,   1);
    issue("rem_by0",   3'b110, 32'd5,          32'd0,          5'd11, 32'd5,          1);
    issue("div_ovf",   3'b100, 32'h80000000,   32'hFFFFFFFF,   5'd12, 32'h80000000,   1);
    issue("rem_ovf",   3'b110, 32'h80000000,   32'hFFFFFFFF,   5'd0,  32'd0,          1);
    issue("mulhu_max", 3'b011, 32'hFFFFFFFF,   32'hFFFFFFFF,   5'd13, 32'hFFFFFFFE,   33);
    issue("mulh_m1",   3'b001, 32'hFFFFFFFF,   32'hFFFFFFFF,   5'd14, 32'd0,          33);
    issue("mulhsu_m1", 3'b010, 32'hFFFFFFFF,   32'hFFFFFFFF,   5'd15, 32'hFFFFFFFF,   33);

    // Flush during CALC cycle 10: back to IDLE, no done, result held
    @(posedge clk); #1;
    op_EX = 3'b101; src1_EX = 32'd100; src2_EX = 32'd7; wr_EX = 5'd7; start_EX = 1'b1;
    repeat (10) @(posedge clk);
    #1 flush = 1'b1;
    check("flush_busy_before", 32'(busy), 32'd1);
    @(posedge clk); #1;
    flush = 1'b0; start_EX = 1'b0;
    @(negedge clk);
    check("flush_busy_after", 32'(busy), 32'd0);
    check("flush_done", 32'(done), 32'd0);
    check("flush_result_held", result, 32'hFFFFFFFF);
    check("flush_wr_held", 32'(wr_out), 32'd15);
    repeat (40) @(negedge clk);

    // Flush together with start in IDLE: request is dropped
    @(posedge clk); #1;
    op_EX = 3'b000; src1_EX = 32'd3; src2_EX = 32'd3; wr_EX = 5'd1;
    start_EX = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    start_EX = 1'b0; flush = 1'b0;
    check("flush_start_idle", 32'(busy), 32'd0);
    repeat (40) @(negedge clk);

    // Reset asserted mid-CALC clears outputs immediately
    @(posedge clk); #1;
    op_EX = 3'b000; src1_EX = 32'd3; src2_EX = 32'd3; wr_EX = 5'd2; start_EX = 1'b1;
    repeat (5) @(posedge clk);
    #2 check("pre_rst_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    start_EX = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_result", result, 32'd0);
    check("mid_rst_wr", 32'(wr_out), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Same operands back-to-back: cached when the feature is present; unsigned variant never hits
    issue("div_100_7",  3'b100, 32'd100, 32'd7, 5'd8,  32'd14, 33);
    issue("rem_100_7",  3'b110, 32'd100, 32'd7, 5'd16, 32'd2,  CLAT);
    issue("remu_100_7", 3'b111, 32'd100, 32'd7, 5'd17, 32'd2,  33);

    repeat (5) @(negedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
